// File: rtl/axi4_rd_arbiter_if.sv
// Bus bundle for the two-requester AXI4 read arbiter: requester AR/R ports plus the shared master AR/R channel.
// The arbiter connects through 'master' (it masters the AXI bus); the surrounding system uses 'slave'.
interface axi4_rd_arbiter_if #(
   parameter int AW  = 49,
   parameter int DW  = 128,
   parameter int IDW = 6
);
   logic [AW-1:0]  rq0_araddr;
   logic [7:0]     rq0_arlen;
   logic           rq0_arvalid;
   logic           rq0_arready;
   logic [DW-1:0]  rq0_rdata;
   logic [1:0]     rq0_rresp;
   logic           rq0_rlast;
   logic           rq0_rvalid;
   logic           rq0_rready;
   logic [3:0]     rq0_outst;

   logic [AW-1:0]  rq1_araddr;
   logic [7:0]     rq1_arlen;
   logic           rq1_arvalid;
   logic           rq1_arready;
   logic [DW-1:0]  rq1_rdata;
   logic [1:0]     rq1_rresp;
   logic           rq1_rlast;
   logic           rq1_rvalid;
   logic           rq1_rready;
   logic [3:0]     rq1_outst;

   logic [IDW-1:0] m_arid;
   logic [AW-1:0]  m_araddr;
   logic [7:0]     m_arlen;
   logic [2:0]     m_arsize;
   logic [1:0]     m_arburst;
   logic           m_arvalid;
   logic           m_arready;
   logic [IDW-1:0] m_rid;
   logic [DW-1:0]  m_rdata;
   logic [1:0]     m_rresp;
   logic           m_rlast;
   logic           m_rvalid;
   logic           m_rready;
   logic           rid_err;

   modport master (
      input  rq0_araddr, rq0_arlen, rq0_arvalid, rq0_rready,
      output rq0_arready, rq0_rdata, rq0_rresp, rq0_rlast, rq0_rvalid, rq0_outst,
      input  rq1_araddr, rq1_arlen, rq1_arvalid, rq1_rready,
      output rq1_arready, rq1_rdata, rq1_rresp, rq1_rlast, rq1_rvalid, rq1_outst,
      output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
      input  m_arready,
      input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
      output m_rready, rid_err
   );

   modport slave (
      output rq0_araddr, rq0_arlen, rq0_arvalid, rq0_rready,
      input  rq0_arready, rq0_rdata, rq0_rresp, rq0_rlast, rq0_rvalid, rq0_outst,
      output rq1_araddr, rq1_arlen, rq1_arvalid, rq1_rready,
      input  rq1_arready, rq1_rdata, rq1_rresp, rq1_rlast, rq1_rvalid, rq1_outst,
      input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
      output m_arready,
      output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
      input  m_rready, rid_err
   );
endinterface

// File: rtl/axi4_rd_arbiter.sv
// Round-robin sharing of one AXI4 read channel between two requesters, with ID-tagged R routing
// and a per-requester cap on outstanding bursts.
module axi4_rd_arbiter #(
   parameter int AW        = 49,
   parameter int DW        = 128,
   parameter int IDW       = 6,
   parameter int MAX_OUTST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   axi4_rd_arbiter_if.master bus
);
   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

   logic           m_arvalid_q;
   logic [AW-1:0]  m_araddr_q;
   logic [7:0]     m_arlen_q;
   logic [IDW-1:0] m_arid_q;
   logic           last_grant_q;
   logic           rid_err_q;
   logic           rid_err_d;

   logic           slot_free;
   logic           rid_bad;
   logic           r_last_hs;
   logic [1:0]     rq_arvalid;
   logic [1:0]     rq_rready;
   logic [1:0]     elig;
   logic [1:0]     grant;
   logic [1:0]     route;
   logic [1:0]     r_dec;
   logic [1:0]     underflow;
   logic [1:0][3:0] outst_all;

   assign rq_arvalid = {bus.rq1_arvalid, bus.rq0_arvalid};
   assign rq_rready  = {bus.rq1_rready,  bus.rq0_rready};

   assign slot_free = ~m_arvalid_q | bus.m_arready;

   // On a tie the requester that did not win last time gets the slot.
   assign grant[0] = slot_free & elig[0] & (~elig[1] | last_grant_q);
   assign grant[1] = slot_free & elig[1] & (~elig[0] | ~last_grant_q);

   assign route[0] = (bus.m_rid == IDW'(0));
   assign route[1] = (bus.m_rid == IDW'(1));
   assign rid_bad  = ~|route;

   // Beats with an unknown ID are sunk so a misbehaving slave cannot wedge the channel.
   assign bus.m_rready = route[0] ? rq_rready[0] : (route[1] ? rq_rready[1] : 1'b1);
   assign r_last_hs    = bus.m_rvalid & bus.m_rready & bus.m_rlast;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         logic [3:0] cnt_q;
         logic [3:0] cnt_d;

         assign elig[gi]      = rq_arvalid[gi] & (cnt_q < MAX_CNT);
         assign r_dec[gi]     = r_last_hs & route[gi];
         assign underflow[gi] = r_dec[gi] & (cnt_q == 4'd0);
         assign outst_all[gi] = cnt_q;

         always_comb begin
            cnt_d = cnt_q;
            if (grant[gi] & ~r_dec[gi])
               cnt_d = cnt_q + 4'd1;
            else if (~grant[gi] & r_dec[gi] & ~underflow[gi])
               cnt_d = cnt_q - 4'd1;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= 4'd0;
            else        cnt_q <= cnt_d;
         end
      end
   endgenerate

   assign rid_err_d = rid_err_q | (bus.m_rvalid & rid_bad) | (|underflow);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_arvalid_q  <= 1'b0;
         m_araddr_q   <= '0;
         m_arlen_q    <= '0;
         m_arid_q     <= '0;
         last_grant_q <= 1'b1;
         rid_err_q    <= 1'b0;
      end else begin
         rid_err_q <= rid_err_d;
         if (slot_free) begin
            if (|grant) begin
               m_arvalid_q  <= 1'b1;
               m_araddr_q   <= grant[1] ? bus.rq1_araddr : bus.rq0_araddr;
               m_arlen_q    <= grant[1] ? bus.rq1_arlen  : bus.rq0_arlen;
               m_arid_q     <= grant[1] ? IDW'(1) : IDW'(0);
               last_grant_q <= grant[1];
            end else begin
               m_arvalid_q <= 1'b0;
            end
         end
      end
   end

   assign bus.rq0_arready = grant[0];
   assign bus.rq1_arready = grant[1];
   assign bus.rq0_outst   = outst_all[0];
   assign bus.rq1_outst   = outst_all[1];

   assign bus.rq0_rvalid  = bus.m_rvalid & route[0];
   assign bus.rq1_rvalid  = bus.m_rvalid & route[1];
   assign bus.rq0_rdata   = bus.m_rdata;
   assign bus.rq1_rdata   = bus.m_rdata;
   assign bus.rq0_rresp   = bus.m_rresp;
   assign bus.rq1_rresp   = bus.m_rresp;
   assign bus.rq0_rlast   = bus.m_rlast;
   assign bus.rq1_rlast   = bus.m_rlast;

   assign bus.m_arvalid   = m_arvalid_q;
   assign bus.m_araddr    = m_araddr_q;
   assign bus.m_arlen     = m_arlen_q;
   assign bus.m_arid      = m_arid_q;
   assign bus.m_arsize    = 3'b100;
   assign bus.m_arburst   = 2'b01;
   assign bus.rid_err     = rid_err_q;
endmodule

// File: doc/axi4_rd_arbiter.md
Name: axi4_rd_arbiter

Overview:
- Shares one AXI4 master read channel (AR + R) between two ring-buffer DMA requesters, e.g. the PS-to-PL ring readers feeding two accelerator FIFOs.
- Arbitrates AR requests round-robin and registers the AR output.
- Tags each burst with the requester index in ARID and routes R beats back by RID.
- Enforces a per-requester outstanding-burst limit so one requester cannot starve the other.

Parameters:
AW, 49, AXI address width
DW, 128, AXI data width
IDW, 6, AXI ID width
MAX_OUTST, 4, max outstanding bursts per requester (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
rq0_araddr  input  AW  requester 0 burst address
rq0_arlen  input  8  requester 0 burst length (AXI encoding)
rq0_arvalid  input  1  requester 0 request valid
rq0_arready  output  1  requester 0 request accepted
rq0_rdata  output  DW  requester 0 read data
rq0_rresp  output  2  requester 0 read response
rq0_rlast  output  1  requester 0 last beat
rq0_rvalid  output  1  requester 0 data valid
rq0_rready  input  1  requester 0 data ready
rq0_outst  output  4  requester 0 outstanding bursts
rq1_* (araddr, arlen, arvalid, arready, rdata, rresp, rlast, rvalid, rready, outst): same widths and meanings as rq0_*, for requester 1
m_arid  output  IDW  master ARID
m_araddr  output  AW  master ARADDR
m_arlen  output  8  master ARLEN
m_arsize  output  3  constant 3'b100
m_arburst  output  2  constant 2'b01 (INCR)
m_arvalid  output  1  master ARVALID
m_arready  input  1  master ARREADY
m_rid  input  IDW  master RID
m_rdata  input  DW  master RDATA
m_rresp  input  2  master RRESP
m_rlast  input  1  master RLAST
m_rvalid  input  1  master RVALID
m_rready  output  1  master RREADY
rid_err  output  1  sticky: R beat with unknown RID seen

Behaviour:
Reset (rst_n low, asynchronous):
- m_arvalid=0, m_araddr/m_arlen/m_arid=0.
- rq0_outst=rq1_outst=0, rid_err=0.
- Round-robin pointer last_grant=1, so requester 0 wins the first tie.
- Deasserting reset mid-burst drops all tracking; the system must quiesce the interconnect first.

AR slot:
- slot_free = ~m_arvalid | m_arready.

Eligibility:
- rqN is eligible when rqN_arvalid=1 and rqN_outst < MAX_OUTST.

Grant (same cycle, combinational):
- When slot_free and at least one requester is eligible, grant exactly one.
- If both are eligible, grant the one != last_grant.
- rqN_arready=1 only for the granted N in that cycle; rqN_arready=0 whenever slot_free=0.

Grant registration (next edge):
- m_arvalid<=1; m_araddr/m_arlen <= granted request; m_arid <= N zero-extended; last_grant <= N.
- If slot_free and no requester is eligible: m_arvalid<=0.
- m_ar* hold stable while m_arvalid & ~m_arready.
- Throughput is one AR per cycle; AR latency is one cycle from acceptance to m_arvalid.

Outstanding counters:
- rqN_outst increments on grant.
- rqN_outst decrements on an R handshake with rlast=1 routed to N.
- Simultaneous increment and decrement leaves the count unchanged.
- The counter saturates by construction, because eligibility blocks grants at MAX_OUTST.

R routing (combinational, no buffering):
- m_rid==0 -> requester 0; m_rid==1 -> requester 1.
- rqN_rvalid = m_rvalid & route==N.
- rq*_rdata/rresp/rlast follow master R unconditionally.
- m_rready = rqN_rready of the routed requester.
- Any other m_rid value:
  - m_rready=1 (beat sunk), neither requester sees rvalid.
  - rid_err<=1 (sticky until reset).
  - Outstanding counters are unaffected.
- R beats with m_rresp != 0 pass through unchanged; the arbiter does not act on them.
- Decrementing a counter at 0 must not occur with a conforming slave; if it does, the counter stays at 0 and rid_err<=1.

Test Plan:
- Reset, then rq0 requests addr 0x1000, len 1 -> rq0_arready=1 same cycle; next cycle m_arvalid=1, m_araddr=0x1000, m_arlen=1, m_arid=0; rq0_outst=1.
- Both requesters valid continuously, m_arready=1 -> grants alternate 0,1,0,1; m_arid sequence 0,1,0,1; one AR per cycle.
- rq1 issues 4 bursts with no R returned (MAX_OUTST=4) -> rq1_arready stays 0 on the 5th request while rq0 still gets granted. Return one rlast for RID 1 -> rq1 is granted on the next free slot.
- m_arready held 0 for 3 cycles with m_arvalid=1 -> m_ar* stable, both rq*_arready=0. On release the next grant loads in the same cycle.
- Interleaved R beats with RID 0, 1, 0, rq0_rready=0 on the third beat -> m_rready=0 that cycle, beat held. Routing delivers beats only to the matching requester; the rlast handshakes decrement the correct counters. A grant on the same edge as an rlast decrement leaves outst unchanged.
- R beat with m_rid=5 -> m_rready=1, no rqN_rvalid, rid_err=1 and stays 1 until rst_n asserted low asynchronously mid-cycle, which clears all state immediately.
